// File: rtl/regfile_responder.sv
// Register file with a valid/ready request channel and an in-order response FIFO.
// Register 0 reads as zero. A clear request sweeps every register before it
// returns its single response.
module regfile_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqClear,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqWAddr,
  input  logic [ADDR_WIDTH-1:0] ReqRAddr1,
  input  logic [ADDR_WIDTH-1:0] ReqRAddr2,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [DATA_WIDTH-1:0] RespData1,
  output logic [DATA_WIDTH-1:0] RespData2,
  output logic [1:0]            RespKind
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;
  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  typedef enum logic [1:0] {
    KIND_READ  = 2'b00,
    KIND_WRITE = 2'b01,
    KIND_CLEAR = 2'b10
  } kind_e;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  push;
  logic                  pop;
  logic                  accept;
  logic [DATA_WIDTH-1:0] push_d1, push_d2;
  kind_e                 push_kind;
  logic [DATA_WIDTH-1:0] rd1, rd2;

  logic [DATA_WIDTH-1:0] fifo_d1_q   [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d2_q   [RESP_DEPTH];
  logic [1:0]            fifo_kind_q [RESP_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ReqReady  = (state_q == ST_IDLE) && (count_q < CNT_W'(RESP_DEPTH));
  assign accept    = ReqValid && ReqReady;
  assign RespValid = (count_q != '0);
  assign pop       = RespValid && RespReady;
  assign RespData1 = fifo_d1_q[rd_ptr_q];
  assign RespData2 = fifo_d2_q[rd_ptr_q];
  assign RespKind  = fifo_kind_q[rd_ptr_q];

  // Write-first read ports: a same-request write to the read address is forwarded.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ReqRAddr1 != '0) begin
      if (ReqWrite && (ReqWAddr != '0) && (ReqRAddr1 == ReqWAddr)) rd1 = ReqData;
      else                                                         rd1 = regs_q[ReqRAddr1];
    end
    if (ReqRAddr2 != '0) begin
      if (ReqWrite && (ReqWAddr != '0) && (ReqRAddr2 == ReqWAddr)) rd2 = ReqData;
      else                                                         rd2 = regs_q[ReqRAddr2];
    end
  end

  // Next-state, register-file write port and response push selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_addr   = ReqWAddr;
    wr_data   = ReqData;
    push      = 1'b0;
    push_d1   = rd1;
    push_d2   = rd2;
    push_kind = KIND_READ;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ReqClear) begin
            state_d = ST_CLEAR;
            cnt_d   = ADDR_WIDTH'(1);
          end else begin
            push      = 1'b1;
            push_kind = ReqWrite ? KIND_WRITE : KIND_READ;
            wr_en     = ReqWrite && (ReqWAddr != '0);
          end
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        // Last sweep address: queue the clear response on the same edge.
        if (cnt_q == '1) begin
          push      = 1'b1;
          push_d1   = '0;
          push_d2   = '0;
          push_kind = KIND_CLEAR;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and sweep counter.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register storage; entry 0 is never written so it stays zero.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Response FIFO: circular buffer, head drives the response outputs directly.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
        fifo_d1_q[i]   <= '0;
        fifo_d2_q[i]   <= '0;
        fifo_kind_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_d1_q[wr_ptr_q]   <= push_d1;
        fifo_d2_q[wr_ptr_q]   <= push_d2;
        fifo_kind_q[wr_ptr_q] <= push_kind;
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
